// File: rtl/sfr_serial_rx.sv
// sfr_serial_rx: memory-mapped 8N1 serial receiver with one-byte buffer and status flags
//   CLK    in    system clock, rising edge
//   RST    in    asynchronous active-low reset
//   RABUS  in    RAM address bus
//   DBUS   inout data bus, driven only during a selected read
//   RCS    in    chip select
//   RWE    in    write enable (wins over ROE)
//   ROE    in    read enable
//   rx_in  in    asynchronous serial line, idle high
//   rx_irq out   byte-available level
module sfr_serial_rx #(
  parameter logic [7:0] DATA_ADDR = 8'hFC,
  parameter logic [7:0] STAT_ADDR = 8'hFD,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RABUS,
  inout  wire  [15:0] DBUS,
  input  logic        RCS,
  input  logic        RWE,
  input  logic        ROE,
  input  logic        rx_in,
  output logic        rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, data;
  logic s1, s2, valid, ferr, ovr, armed, rd_q;
  logic rd, rd_data, rd_stat, rd_clr, wr_stat, done, good, bad;
  assign rd = RCS & ROE & ~RWE;
  assign rd_data = rd & (RABUS == DATA_ADDR);
  assign rd_stat = rd & (RABUS == STAT_ADDR);
  // valid is consumed once per read, however long the strobe is held
  assign rd_clr = rd_data & ~rd_q;
  assign wr_stat = RCS & RWE & (RABUS == STAT_ADDR);
  assign done = (state == STOP) && (cnt == FULL);
  assign good = done & s2;
  assign bad = done & ~s2;
  assign DBUS = rd_data ? {8'h00, data} : rd_stat ? {13'b0, ovr, ferr, valid} : 16'bz;
  assign rx_irq = valid;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
      armed <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      rd_q <= rd_data;
      case (state)
        // a start edge counts only after the line has been seen idle, so a break cannot retrigger
        IDLE: begin
          cnt <= '0;
          if (s2) armed <= 1'b1;
          else if (armed) begin
            armed <= 1'b0;
            state <= START;
          end
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          bit_idx <= '0;
          state <= s2 ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          shift[bit_idx] <= s2;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
      data <= good ? shift : data;
      valid <= good | (valid & ~rd_clr);
      // a new error/overrun on the same edge as a clear write keeps the flag set
      ferr <= bad | (ferr & ~(wr_stat & DBUS[1]));
      ovr <= (good & valid & ~rd_clr) | (ovr & ~(wr_stat & DBUS[2]));
    end
  end
endmodule

// File: tb/tb_sfr_serial_rx.sv
// tb_sfr_serial_rx: directed self-checking bench for sfr_serial_rx
module tb_sfr_serial_rx;
  localparam int CPB = 16;
  localparam logic [7:0] DA = 8'hFC;
  localparam logic [7:0] SA = 8'hFD;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [7:0] RABUS = 8'h00;
  logic RCS = 1'b0;
  logic RWE = 1'b0;
  logic ROE = 1'b0;
  logic rx_in = 1'b1;
  logic rx_irq;
  logic tb_en = 1'b0;
  logic [15:0] tb_val = 16'h0000;
  wire [15:0] DBUS;
  int checks = 0;
  int errors = 0;
  assign DBUS = tb_en ? tb_val : 16'bz;
  always #5 CLK = ~CLK;
  sfr_serial_rx dut (
    .CLK(CLK), .RST(RST), .RABUS(RABUS), .DBUS(DBUS), .RCS(RCS),
    .RWE(RWE), .ROE(ROE), .rx_in(rx_in), .rx_irq(rx_irq)
  );
  task automatic send(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx_in = stop;
    repeat (CPB) @(negedge CLK);
    rx_in = 1'b1;
  endtask
  task automatic rd_bus(input logic [7:0] a, input int n, output logic [15:0] first, output logic [15:0] last);
    @(negedge CLK);
    RABUS = a; RCS = 1'b1; ROE = 1'b1; RWE = 1'b0;
    #1 first = DBUS;
    last = first;
    for (int i = 1; i < n; i++) begin
      @(negedge CLK);
      #1 last = DBUS;
    end
    @(negedge CLK);
    RCS = 1'b0; ROE = 1'b0;
  endtask
  task automatic wr_bus(input logic [7:0] a, input logic [15:0] v, input logic oe, output logic [15:0] seen);
    @(negedge CLK);
    RABUS = a; tb_val = v; tb_en = 1'b1; RCS = 1'b1; RWE = 1'b1; ROE = oe;
    #1 seen = DBUS;
    @(negedge CLK);
    RCS = 1'b0; RWE = 1'b0; ROE = 1'b0; tb_en = 1'b0;
  endtask
  task automatic probe(input logic [7:0] a, input logic cs, input logic we, input logic oe, output logic [15:0] seen);
    @(negedge CLK);
    RABUS = a; tb_val = 16'h0000; tb_en = 1'b1; RCS = cs; RWE = we; ROE = oe;
    #1 seen = DBUS;
    @(negedge CLK);
    RCS = 1'b0; RWE = 1'b0; ROE = 1'b0; tb_en = 1'b0;
  endtask
  task automatic test_reset;
    logic [15:0] a, b;
    repeat (3) @(negedge CLK);
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", rx_irq); end
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL reset_stat got %h want 0000", a); end
    rd_bus(DA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", a); end
    probe(DA, 1'b0, 1'b0, 1'b0, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL reset_release got %h want 0000", a); end
    RST = 1'b1;
    repeat (5) @(negedge CLK);
  endtask
  task automatic test_rx_byte;
    logic [15:0] a, b;
    send(8'hA5, 1'b1);
    repeat (2) @(negedge CLK);
    checks++; if (rx_irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got %b want 1", rx_irq); end
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL rx_stat got %h want 0001", a); end
    rd_bus(DA, 3, a, b);
    checks++; if (a !== 16'h00A5) begin errors++; $display("FAIL rx_data got %h want 00A5", a); end
    checks++; if (b !== 16'h00A5) begin errors++; $display("FAIL rx_data_held got %h want 00A5", b); end
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clr got %b want 0", rx_irq); end
  endtask
  task automatic test_overrun;
    logic [15:0] a, b;
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    repeat (2) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0005) begin errors++; $display("FAIL ovr_stat got %h want 0005", a); end
    wr_bus(SA, 16'h0004, 1'b0, a);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL ovr_clear got %h want 0001", a); end
    wr_bus(SA, 16'h0001, 1'b0, a);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL valid_wr_ignored got %h want 0001", a); end
    wr_bus(DA, 16'h0000, 1'b1, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL we_oe_drive got %h want 0000", a); end
    rd_bus(DA, 1, a, b);
    checks++; if (a !== 16'h00C3) begin errors++; $display("FAIL data_wr_ignored got %h want 00C3", a); end
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL ovr_final got %h want 0000", a); end
  endtask
  task automatic test_frame_error;
    logic [15:0] a, b;
    send(8'h55, 1'b0);
    repeat (2) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0002) begin errors++; $display("FAIL ferr_stat got %h want 0002", a); end
    rd_bus(DA, 1, a, b);
    checks++; if (a !== 16'h00C3) begin errors++; $display("FAIL ferr_data got %h want 00C3", a); end
    wr_bus(SA, 16'h0002, 1'b0, a);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL ferr_clear got %h want 0000", a); end
  endtask
  task automatic test_break;
    logic [15:0] a, b;
    rx_in = 1'b0;
    repeat (400) @(negedge CLK);
    rx_in = 1'b1;
    repeat (20) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0002) begin errors++; $display("FAIL break_stat got %h want 0002", a); end
    wr_bus(SA, 16'h0002, 1'b0, a);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL break_clear got %h want 0000", a); end
  endtask
  task automatic test_glitch;
    logic [15:0] a, b;
    rx_in = 1'b0;
    repeat (6) @(negedge CLK);
    rx_in = 1'b1;
    repeat (200) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL glitch_stat got %h want 0000", a); end
    send(8'h96, 1'b1);
    repeat (2) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL glitch_next got %h want 0001", a); end
  endtask
  task automatic test_reset_midframe;
    logic [15:0] a, b;
    fork
      send(8'hF0, 1'b1);
      begin
        repeat (5 * CPB + 4) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b want 0", rx_irq); end
        rd_bus(DA, 1, a, b);
        checks++; if (a !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got %h want 0000", a); end
        rd_bus(SA, 1, a, b);
        checks++; if (a !== 16'h0000) begin errors++; $display("FAIL mid_rst_stat got %h want 0000", a); end
        RST = 1'b1;
      end
    join
    repeat (20) @(negedge CLK);
    send(8'h81, 1'b1);
    repeat (2) @(negedge CLK);
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL post_rst_stat got %h want 0001", a); end
    rd_bus(DA, 1, a, b);
    checks++; if (a !== 16'h0081) begin errors++; $display("FAIL post_rst_data got %h want 0081", a); end
  endtask
  task automatic test_back_to_back;
    logic [15:0] a, b, old;
    send(8'h11, 1'b1);
    fork
      send(8'h7E, 1'b1);
      begin
        repeat (154) @(negedge CLK);
        RABUS = DA; RCS = 1'b1; ROE = 1'b1;
        #1 old = DBUS;
        @(negedge CLK);
        RCS = 1'b0; ROE = 1'b0;
      end
    join
    checks++; if (old !== 16'h0011) begin errors++; $display("FAIL b2b_old got %h want 0011", old); end
    rd_bus(SA, 1, a, b);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL b2b_stat got %h want 0001", a); end
  endtask
  task automatic test_idle_bus;
    logic [15:0] a, b;
    probe(8'hFE, 1'b1, 1'b0, 1'b1, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL idle_addr_fe got %h want 0000", a); end
    probe(8'h00, 1'b1, 1'b0, 1'b1, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL idle_addr_00 got %h want 0000", a); end
    probe(DA, 1'b0, 1'b0, 1'b1, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL idle_no_cs got %h want 0000", a); end
    probe(SA, 1'b1, 1'b0, 1'b0, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL idle_no_oe got %h want 0000", a); end
    probe(DA, 1'b1, 1'b1, 1'b1, a);
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL idle_we_oe got %h want 0000", a); end
    rd_bus(DA, 1, a, b);
    checks++; if (a !== 16'h007E) begin errors++; $display("FAIL b2b_data got %h want 007E", a); end
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL final_irq got %b want 0", rx_irq); end
  endtask
  initial begin
    test_reset;
    test_rx_byte;
    test_overrun;
    test_frame_error;
    test_break;
    test_glitch;
    test_reset_midframe;
    test_back_to_back;
    test_idle_bus;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
